// File: rtl/tile_operand_mem.sv
// Operand store for a matrix-vector tile: in-vector, matrix and out-vector regions with a registered read port.
// Define TILE_OPERAND_MEM_ACC_EN to enable accumulate writes into the out-vector region.
module tile_operand_mem #(
  parameter int NUM_SLOTS = 4,
  parameter int VEC_LEN   = 4,
  parameter int MAT_R     = 8,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 32,
  parameter int SLOT_BITS = $clog2(NUM_SLOTS),
  parameter int ROW_BITS  = $clog2(MAT_R),
  parameter int DATA_W    =
    OUT_BITS * ((VEC_LEN > MAT_R) ? VEC_LEN : MAT_R)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [1:0]           wr_region,
  input  logic [SLOT_BITS-1:0] wr_slot,
  input  logic [ROW_BITS-1:0]  wr_row,
  input  logic                 wr_acc,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [1:0]           rd_region,
  input  logic [SLOT_BITS-1:0] rd_slot,
  input  logic [ROW_BITS-1:0]  rd_row,
  input  logic                 rd_burst,
  output logic                 rd_resp_valid,
  input  logic                 rd_resp_ready,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_resp_err,
  output logic                 rd_resp_last,
  output logic                 wr_err
);

  localparam int VW = VEC_LEN * IN_BITS;
  localparam int MW = VEC_LEN * OUT_BITS;
  localparam int OW = MAT_R * OUT_BITS;
  localparam logic [ROW_BITS-1:0] LAST_ROW =
    ROW_BITS'(MAT_R - 1);

  typedef enum logic [1:0] {
    IDLE,
    RESP,
    BURST
  } state_e;

  logic [VW-1:0] vec_q [NUM_SLOTS];
  logic [MW-1:0] mat_q [NUM_SLOTS][MAT_R];
  logic [OW-1:0] out_q [NUM_SLOTS];

  state_e                        state_q, state_d;
  logic                          rdy_q;
  logic [3:0][NUM_SLOTS-1:0]     vld_q, vld_d;
  logic [SLOT_BITS-1:0]          slot_q, slot_d;
  logic [ROW_BITS-1:0]           row_q, row_d;
  logic [DATA_W-1:0]             data_q, data_d;
  logic                          err_q, err_d;
  logic                          last_q, last_d;
  logic                          werr_q, werr_d;

  logic                  wr_fire, rd_fire, resp_fire;
  logic                  is_burst, acc_err, bst_err;
  logic [ROW_BITS-1:0]   acc_row, nxt_row;
  logic [DATA_W-1:0]     acc_data, bst_data;
  logic [OW-1:0]         out_wd;

  assign wr_ready      = rdy_q;
  assign rd_req_ready  = rdy_q && (state_q == IDLE);
  assign rd_resp_valid = (state_q != IDLE);
  assign rd_data       = data_q;
  assign rd_resp_err   = err_q;
  assign rd_resp_last  = last_q;
  assign wr_err        = werr_q;

  assign wr_fire   = wr_valid && rdy_q;
  assign rd_fire   = rd_req_valid && rd_req_ready;
  assign resp_fire = rd_resp_valid && rd_resp_ready;
  assign is_burst  = rd_burst && (rd_region == 2'd1);
  assign nxt_row   = row_q + ROW_BITS'(1);
  assign werr_d    = wr_fire && (wr_region == 2'd3);

`ifdef TILE_OPERAND_MEM_ACC_EN
  always_comb begin
    out_wd = wr_data[OW-1:0];
    if (wr_acc) begin
      for (int e = 0; e < MAT_R; e++) begin
        out_wd[e*OUT_BITS +: OUT_BITS] =
          (vld_q[2][wr_slot] ?
            out_q[wr_slot][e*OUT_BITS +: OUT_BITS] :
            {OUT_BITS{1'b0}}) +
          wr_data[e*OUT_BITS +: OUT_BITS];
      end
    end
  end
`else
  logic unused_acc;
  assign unused_acc = wr_acc;
  assign out_wd = wr_data[OW-1:0];
`endif

  // Request-time lookup sees storage before any same-edge write.
  always_comb begin
    acc_row  = is_burst ? '0 : rd_row;
    acc_data = '0;
    unique case (1'b1)
      rd_region == 2'd0: acc_data[VW-1:0] = vec_q[rd_slot];
      rd_region == 2'd1: acc_data[MW-1:0] = mat_q[rd_slot][acc_row];
      rd_region == 2'd2: acc_data[OW-1:0] = out_q[rd_slot];
      default:           acc_data = '0;
    endcase
    acc_err = !vld_q[rd_region][rd_slot];
  end

  always_comb begin
    vld_d = vld_q;
    if (wr_fire && (wr_region != 2'd3))
      vld_d[wr_region][wr_slot] = 1'b1;
    if (clear)
      vld_d = '0;
  end

  // Next burst row forwards a same-edge write so it is never missed.
  always_comb begin
    bst_data = '0;
    bst_data[MW-1:0] = mat_q[slot_q][nxt_row];
    if (wr_fire && (wr_region == 2'd1) &&
        (wr_slot == slot_q) && (wr_row == nxt_row))
      bst_data[MW-1:0] = wr_data[MW-1:0];
    bst_err = !vld_d[1][slot_q];
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    row_d   = row_q;
    data_d  = data_q;
    err_d   = err_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (rd_fire) begin
          state_d = is_burst ? BURST : RESP;
          slot_d  = rd_slot;
          row_d   = '0;
          data_d  = acc_err ? '0 : acc_data;
          err_d   = acc_err;
          last_d  = !is_burst;
        end
      end
      RESP: begin
        if (resp_fire) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      BURST: begin
        if (resp_fire) begin
          if (last_q) begin
            state_d = IDLE;
            data_d  = '0;
            err_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            row_d  = nxt_row;
            data_d = bst_err ? '0 : bst_data;
            err_d  = bst_err;
            last_d = (nxt_row == LAST_ROW);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= '0;
      slot_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      vld_q   <= vld_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      data_q  <= data_d;
      err_q   <= err_d;
      last_q  <= last_d;
      werr_q  <= werr_d;
    end
  end

  // Operand storage is deliberately left without reset.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      case (wr_region)
        2'd0:    vec_q[wr_slot] <= wr_data[VW-1:0];
        2'd1:    mat_q[wr_slot][wr_row] <= wr_data[MW-1:0];
        2'd2:    out_q[wr_slot] <= out_wd;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_operand_mem.sv
// Directed bench for tile_operand_mem with a response scoreboard.
module tb_tile_operand_mem;

  localparam int DW = 256;
  localparam logic [DW-1:0] ACC_EXP =
`ifdef TILE_OPERAND_MEM_ACC_EN
    256'd1;
`else
    256'd2;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [1:0]    wr_region = 2'd0;
  logic [1:0]    wr_slot = 2'd0;
  logic [2:0]    wr_row = 3'd0;
  logic          wr_acc = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [1:0]    rd_region = 2'd0;
  logic [1:0]    rd_slot = 2'd0;
  logic [2:0]    rd_row = 3'd0;
  logic          rd_burst = 1'b0;
  logic          rd_resp_valid;
  logic          rd_resp_ready = 1'b1;
  logic [DW-1:0] rd_data;
  logic          rd_resp_err;
  logic          rd_resp_last;
  logic          wr_err;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  tile_operand_mem dut (
    .clock(clock), .reset(reset), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_region(wr_region), .wr_slot(wr_slot),
    .wr_row(wr_row), .wr_acc(wr_acc), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_region(rd_region), .rd_slot(rd_slot),
    .rd_row(rd_row), .rd_burst(rd_burst),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_ready(rd_resp_ready),
    .rd_data(rd_data), .rd_resp_err(rd_resp_err),
    .rd_resp_last(rd_resp_last), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d,
                      input logic e, input logic l);
    exp_q.push_back('{data: d, err: e, last: l});
  endtask

  task automatic wr(input logic [1:0] rg, input logic [1:0] sl,
                    input logic [2:0] rw, input logic acc,
                    input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_region = rg; wr_slot = sl;
    wr_row = rw; wr_acc = acc; wr_data = d;
    cyc();
    wr_valid = 1'b0; wr_acc = 1'b0;
  endtask

  task automatic rd(input logic [1:0] rg, input logic [1:0] sl,
                    input logic [2:0] rw, input logic burst);
    int n = 0;
    rd_req_valid = 1'b1; rd_region = rg; rd_slot = sl;
    rd_row = rw; rd_burst = burst;
    while (!rd_req_ready && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    assert (rd_req_ready === 1'b1) else begin
      failures++;
      $error("FAIL req_accept_timeout observed=%0b expected=1",
             rd_req_ready);
    end
    cyc();
    rd_req_valid = 1'b0; rd_burst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=0",
             exp_q.size());
    end
  endtask

  // Compare every presented response with the scoreboard head.
  always @(negedge clock) begin
    if (rd_resp_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_resp observed=%0h expected=none",
               rd_data);
      end
      if (exp_q.size() != 0) begin
        chk("rd_data", rd_data, exp_q[0].data);
        chk("rd_err", DW'(rd_resp_err), DW'(exp_q[0].err));
        chk("rd_last", DW'(rd_resp_last), DW'(exp_q[0].last));
        if (rd_resp_ready)
          void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #20;
    chk("rst_wr_ready", DW'(wr_ready), '0);
    chk("rst_req_ready", DW'(rd_req_ready), '0);
    chk("rst_resp_valid", DW'(rd_resp_valid), '0);
    chk("rst_data", rd_data, '0);
    chk("rst_err", DW'(rd_resp_err), '0);
    chk("rst_last", DW'(rd_resp_last), '0);
    chk("rst_wr_err", DW'(wr_err), '0);
    #2 reset = 1'b1;
    #1 chk("rel_wr_ready_pre", DW'(wr_ready), '0);
    cyc();
    chk("rel_wr_ready", DW'(wr_ready), DW'(1));
    chk("rel_req_ready", DW'(rd_req_ready), DW'(1));

    push('0, 1'b1, 1'b1);
    rd(2'd2, 2'd3, 3'd0, 1'b0);
    drain();
    push('0, 1'b1, 1'b1);
    rd(2'd3, 2'd0, 3'd0, 1'b0);
    drain();
    wr(2'd3, 2'd0, 3'd0, 1'b0, DW'(32'hDEAD));
    chk("wr_err_pulse", DW'(wr_err), DW'(1));
    cyc();
    chk("wr_err_end", DW'(wr_err), '0);

    wr(2'd0, 2'd1, 3'd0, 1'b0, DW'(32'h04030201));
    push(DW'(32'h04030201), 1'b0, 1'b1);
    rd(2'd0, 2'd1, 3'd0, 1'b0);
    chk("latency1", DW'(rd_resp_valid), DW'(1));
    chk("req_busy", DW'(rd_req_ready), '0);
    cyc();
    chk("req_back", DW'(rd_req_ready), DW'(1));
    drain();
    push(DW'(32'h04030201), 1'b0, 1'b1);
    rd(2'd0, 2'd1, 3'd0, 1'b1);
    drain();

    wr(2'd0, 2'd0, 3'd0, 1'b0, DW'(8'h55));
    wr_valid = 1'b1; wr_region = 2'd0; wr_slot = 2'd0;
    wr_data = DW'(8'hAA);
    rd_req_valid = 1'b1; rd_region = 2'd0; rd_slot = 2'd0;
    rd_burst = 1'b0;
    push(DW'(8'h55), 1'b0, 1'b1);
    cyc();
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    drain();
    push(DW'(8'hAA), 1'b0, 1'b1);
    rd(2'd0, 2'd0, 3'd0, 1'b0);
    drain();

    for (int r = 0; r < 8; r++)
      wr(2'd1, 2'd0, 3'(r), 1'b0, DW'(r));
    for (int r = 0; r < 8; r++)
      push(DW'(r), 1'b0, r == 7);
    rd(2'd1, 2'd0, 3'd5, 1'b1);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
      rd_resp_ready = (k % 2 == 0);
      cyc();
    end
    rd_resp_ready = 1'b1;
    drain();

    for (int r = 0; r < 7; r++)
      push(DW'(r), 1'b0, 1'b0);
    push(DW'(8'h77), 1'b0, 1'b1);
    rd(2'd1, 2'd0, 3'd0, 1'b1);
    wr_valid = 1'b1; wr_region = 2'd1; wr_slot = 2'd0;
    wr_row = 3'd7; wr_data = DW'(8'h77);
    cyc();
    wr_valid = 1'b0;
    drain();

    wr(2'd2, 2'd0, 3'd0, 1'b0, DW'(32'hFFFFFFFF));
    wr(2'd2, 2'd0, 3'd0, 1'b1, DW'(32'h2));
    push(ACC_EXP, 1'b0, 1'b1);
    rd(2'd2, 2'd0, 3'd0, 1'b0);
    drain();

    wr(2'd0, 2'd1, 3'd0, 1'b0, DW'(8'h33));
    rd_resp_ready = 1'b0;
    push(DW'(8'h33), 1'b0, 1'b1);
    rd(2'd0, 2'd1, 3'd0, 1'b0);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cyc();
    rd_resp_ready = 1'b1;
    drain();
    wr(2'd0, 2'd2, 3'd0, 1'b0, DW'(8'h11));
    clear = 1'b1;
    wr(2'd0, 2'd3, 3'd0, 1'b0, DW'(8'h22));
    clear = 1'b0;
    push('0, 1'b1, 1'b1);
    rd(2'd0, 2'd2, 3'd0, 1'b0);
    drain();
    push('0, 1'b1, 1'b1);
    rd(2'd0, 2'd3, 3'd0, 1'b0);
    drain();

    for (int r = 0; r < 8; r++)
      wr(2'd1, 2'd0, 3'(r), 1'b0, DW'(r));
    for (int r = 0; r < 8; r++)
      push(DW'(r), 1'b0, r == 7);
    rd(2'd1, 2'd0, 3'd0, 1'b1);
    cyc();
    cyc();
    chk("third_valid", DW'(rd_resp_valid), DW'(1));
    chk("third_data", rd_data, DW'(2));
    reset = 1'b0;
    #1;
    chk("abort_valid", DW'(rd_resp_valid), '0);
    chk("abort_req_ready", DW'(rd_req_ready), '0);
    chk("abort_data", rd_data, '0);
    exp_q.delete();
    #4 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_req_ready", DW'(rd_req_ready), DW'(1));
    chk("post_wr_ready", DW'(wr_ready), DW'(1));
    repeat (12) cyc();
    chk("no_stale", DW'(rd_resp_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
